// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen: wide phase-accumulator DDS with phase offset, quarter-wave sine LUT and linear chirp FSM.
// Latency: 3 enabled cycles from accumulator value to o_signal_out; o_valid follows en through 3 stages.
// Backpressure: none; i_en is a clock enable that freezes accumulator, FSM and all pipeline stages.
//
// Ports: clk/rst (sync, active-high); i_en clock enable; i_mode 0=off 1=fixed 2=single sweep 3=up/down sweep;
//   i_start launches a sweep; i_freq_start/i_freq_stop/i_freq_step sweep words; i_phase_offset added before LUT;
//   o_busy sweeping; o_freq_cur applied frequency word; o_phase_out accumulator; o_signal_out signed sample;
//   o_valid live sample.
// Optional macro DDS_DITHER_EN: 16-bit Galois LFSR dither added below the LUT address bits.
module dds_sweep_gen #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [1:0]                i_mode,
    input  logic                      i_start,
    input  logic [PHASE_W-1:0]        i_freq_start,
    input  logic [PHASE_W-1:0]        i_freq_stop,
    input  logic [PHASE_W-1:0]        i_freq_step,
    input  logic [PHASE_W-1:0]        i_phase_offset,
    output logic                      o_busy,
    output logic [PHASE_W-1:0]        o_freq_cur,
    output logic [PHASE_W-1:0]        o_phase_out,
    output logic signed [DATA_W-1:0]  o_signal_out,
    output logic                      o_valid
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_FIXED = 2'd1;
    localparam logic [1:0] MODE_CONT  = 2'd3;
    localparam int         QDEPTH     = 2**(ADDR_W-2);
    localparam real        PI         = 3.14159265358979323846;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP_UP, ST_SWEEP_DOWN, ST_HOLD} state_t;

    // Quarter-wave table sampled at half-LSB offsets so that mirroring the index
    // reproduces the second quarter exactly and no entry sits on a zero crossing.
    function automatic logic [DATA_W-1:0] lut_entry(input int i);
        real amp;
        real x;
        amp = real'((2**(DATA_W-1)) - 1);
        x   = amp * $sin(2.0 * PI * (real'(i) + 0.5) / real'(2**ADDR_W));
        return DATA_W'($rtoi(x + 0.5));
    endfunction

    logic [DATA_W-1:0] w_lut [QDEPTH];
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_lut
        assign w_lut[gi] = lut_entry(gi);
    end

    state_t              r_state, w_state_nxt;
    logic [PHASE_W-1:0]  r_freq, w_freq_nxt;
    logic [PHASE_W-1:0]  r_acc;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_mag;
    logic                r_neg;
    logic [DATA_W-1:0]   r_sig;
    logic [2:0]          r_en_sr;
    logic [PHASE_W-1:0]  w_dither;
    logic [PHASE_W-1:0]  w_p;
    logic [1:0]          w_quad;
    logic [ADDR_W-3:0]   w_idx;
    logic [PHASE_W:0]    w_sum;
    logic signed [PHASE_W:0] w_diff;

`ifdef DDS_DITHER_EN
    localparam int          DITH_W    = PHASE_W - ADDR_W;
    localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

    if (DITH_W < 1 || DITH_W > 16) begin : g_dither_check
        $error("dds_sweep_gen: dither needs 1 <= PHASE_W-ADDR_W <= 16");
    end

    logic [15:0] r_lfsr;

    // Right-shifting Galois LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (i_en) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_dither = PHASE_W'(r_lfsr & DITH_MASK);
`else
    assign w_dither = '0;
`endif

    assign w_p = r_acc + i_phase_offset + w_dither;

    // Accumulator: natural wrap; mode off parks it at zero regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_mode == MODE_OFF) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + r_freq;
        end
    end

    // Stage 1 keeps only the LUT address; the shift consumes the full phase word.
    assign w_quad = r_addr[ADDR_W-1:ADDR_W-2];
    assign w_idx  = w_quad[0] ? ~r_addr[ADDR_W-3:0] : r_addr[ADDR_W-3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_mag  <= '0;
            r_neg  <= 1'b0;
            r_sig  <= '0;
        end else if (i_en) begin
            r_addr <= ADDR_W'(w_p >> (PHASE_W - ADDR_W));
            r_mag  <= w_lut[w_idx];
            r_neg  <= w_quad[1];
            r_sig  <= r_neg ? (~r_mag + 1'b1) : r_mag;
        end
    end

    // Valid tracks en on every clock, not only enabled ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_sr <= '0;
        end else begin
            r_en_sr <= {r_en_sr[1:0], i_en};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_freq  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_freq  <= w_freq_nxt;
        end
    end

    assign w_sum  = {1'b0, r_freq} + {1'b0, i_freq_step};
    assign w_diff = $signed({1'b0, r_freq}) - $signed({1'b0, i_freq_step});

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        if (i_mode == MODE_OFF) begin
            w_state_nxt = ST_IDLE;
            w_freq_nxt  = '0;
        end else if (i_mode == MODE_FIXED) begin
            w_state_nxt = ST_IDLE;
            w_freq_nxt  = i_freq_start;
        end else if (i_en) begin
            if (i_start) begin
                // Empty or inverted range goes straight to HOLD at the start word.
                w_freq_nxt  = i_freq_start;
                w_state_nxt = (i_freq_start >= i_freq_stop) ? ST_HOLD : ST_SWEEP_UP;
            end else begin
                case (r_state)
                    ST_SWEEP_UP: begin
                        if (w_sum >= {1'b0, i_freq_stop}) begin
                            w_freq_nxt  = i_freq_stop;
                            w_state_nxt = (i_mode == MODE_CONT) ? ST_SWEEP_DOWN : ST_HOLD;
                        end else begin
                            w_freq_nxt = w_sum[PHASE_W-1:0];
                        end
                    end
                    ST_SWEEP_DOWN: begin
                        if (w_diff <= $signed({1'b0, i_freq_start})) begin
                            w_freq_nxt  = i_freq_start;
                            w_state_nxt = ST_SWEEP_UP;
                        end else begin
                            w_freq_nxt = w_diff[PHASE_W-1:0];
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    assign o_busy       = (r_state == ST_SWEEP_UP) || (r_state == ST_SWEEP_DOWN);
    assign o_freq_cur   = r_freq;
    assign o_phase_out  = r_acc;
    assign o_signal_out = (i_mode == MODE_OFF) ? '0 : r_sig;
    assign o_valid      = r_en_sr[2] && (i_mode != MODE_OFF);

endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb_dds_sweep_gen: directed and randomized checks of dds_sweep_gen against a sine/sweep reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_dds_sweep_gen;

    localparam int PHASE_W = 16;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam real PI     = 3.14159265358979323846;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic [1:0]               mode;
    logic                     start;
    logic [PHASE_W-1:0]       freq_start, freq_stop, freq_step, phase_offset;
    logic                     busy;
    logic [PHASE_W-1:0]       freq_cur;
    logic [PHASE_W-1:0]       phase_out;
    logic signed [DATA_W-1:0] signal_out;
    logic                     valid;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dds_sweep_gen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .i_en(en), .i_mode(mode), .i_start(start),
        .i_freq_start(freq_start), .i_freq_stop(freq_stop), .i_freq_step(freq_step),
        .i_phase_offset(phase_offset), .o_busy(busy), .o_freq_cur(freq_cur),
        .o_phase_out(phase_out), .o_signal_out(signal_out), .o_valid(valid)
    );

    // Full-period sine evaluated directly at the address's half-LSB point (no folding).
    function automatic logic signed [DATA_W-1:0] ref_sine(input logic [PHASE_W-1:0] p);
        int  a;
        int  r;
        real x;
        a = int'(p >> (PHASE_W - ADDR_W));
        x = real'(2**(DATA_W-1) - 1) * $sin(2.0 * PI * (real'(a) + 0.5) / real'(2**ADDR_W));
        if (x >= 0.0) r = $rtoi(x + 0.5);
        else          r = -$rtoi(-x + 0.5);
        return DATA_W'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 2'd0; start = 1'b0;
        freq_start = '0; freq_stop = '0; freq_step = '0; phase_offset = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'd1; start = 1'b0;
        freq_start = 16'h1234; freq_stop = '0; freq_step = '0; phase_offset = 16'h0777;
        tick(); tick(); tick(); tick();
        n_total++; if ({phase_out, freq_cur} !== 32'h0) $display("FAIL reset_words phase=%h freq=%h want 0", phase_out, freq_cur); else n_pass++;
        n_total++; if (signal_out !== 8'sd0) $display("FAIL reset_signal got %0d want 0", signal_out); else n_pass++;
        n_total++; if ({busy, valid} !== 2'b00) $display("FAIL reset_flags busy=%b valid=%b want 0 0", busy, valid); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        logic signed [DATA_W-1:0] e;
        logic [PHASE_W-1:0]       ep;
        do_reset();
        mode = 2'd1; freq_start = 16'h0100; phase_offset = '0; en = 1'b1;
        for (int n = 1; n <= 263; n++) begin
            tick();
            if (n < 3) begin
                n_total++; if (valid !== 1'b0) $display("FAIL fixed_valid_early n=%0d got %b want 0", n, valid); else n_pass++;
            end else begin
                e = ref_sine(16'(((n < 4) ? 0 : (n - 4) % 256) << 8));
                n_total++; if (signal_out !== e) $display("FAIL fixed_sample n=%0d got %0d want %0d", n, signal_out, e); else n_pass++;
            end
            ep = 16'((n - 1) * 256);
            n_total++; if (phase_out !== ep) $display("FAIL fixed_phase n=%0d got %h want %h", n, phase_out, ep); else n_pass++;
            if (n == 3) begin
                n_total++; if (valid !== 1'b1) $display("FAIL fixed_valid_rise got %b want 1", valid); else n_pass++;
                e = 8'sd2;
                n_total++; if (signal_out !== e) $display("FAIL fixed_first got %0d want %0d", signal_out, e); else n_pass++;
            end
            if (n == 68)  begin e = 8'sd127;  n_total++; if (signal_out !== e) $display("FAIL fixed_addr64 got %0d want %0d", signal_out, e); else n_pass++; end
            if (n == 132) begin e = -8'sd2;   n_total++; if (signal_out !== e) $display("FAIL fixed_addr128 got %0d want %0d", signal_out, e); else n_pass++; end
            if (n == 196) begin e = -8'sd127; n_total++; if (signal_out !== e) $display("FAIL fixed_addr192 got %0d want %0d", signal_out, e); else n_pass++; end
        end
    endtask

    task automatic test_offset();
        logic signed [DATA_W-1:0] e;
        do_reset();
        mode = 2'd1; freq_start = 16'h0100; phase_offset = 16'h4000; en = 1'b1;
        tick(); tick(); tick();
        e = 8'sd127;
        n_total++; if (signal_out !== e) $display("FAIL offset_first got %0d want %0d", signal_out, e); else n_pass++;
        n_total++; if (phase_out !== 16'h0200) $display("FAIL offset_phase got %h want 0200", phase_out); else n_pass++;
        tick(); tick();
        e = ref_sine(16'h4100);
        n_total++; if (signal_out !== e) $display("FAIL offset_later got %0d want %0d", signal_out, e); else n_pass++;
    endtask

    task automatic test_nyquist();
        logic signed [DATA_W-1:0] e;
        do_reset();
        mode = 2'd1; freq_start = 16'h8000; en = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n >= 4) begin
                e = ((n - 4) % 2 == 0) ? 8'sd2 : -8'sd2;
                n_total++; if (signal_out !== e) $display("FAIL nyquist n=%0d got %0d want %0d", n, signal_out, e); else n_pass++;
            end
        end
    endtask

    task automatic test_sweep_single();
        logic [PHASE_W-1:0] ef [6] = '{16'h100, 16'h200, 16'h300, 16'h400, 16'h400, 16'h400};
        int busy_cnt = 0;
        do_reset();
        mode = 2'd2; freq_start = 16'h0100; freq_stop = 16'h0400; freq_step = 16'h0100; en = 1'b1;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL sweep_idle_busy got %b want 0", busy); else n_pass++;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_total++; if (freq_cur !== ef[i]) $display("FAIL sweep_freq i=%0d got %h want %h", i, freq_cur, ef[i]); else n_pass++;
            busy_cnt += int'(busy);
            tick();
        end
        n_total++; if (busy_cnt != 3) $display("FAIL sweep_busy_cycles got %0d want 3", busy_cnt); else n_pass++;
        // restart from HOLD, then restart while busy
        start = 1'b1; tick(); start = 1'b0;
        n_total++; if ({busy, freq_cur} !== {1'b1, 16'h0100}) $display("FAIL sweep_restart got busy=%b freq=%h want 1 0100", busy, freq_cur); else n_pass++;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n_total++; if (freq_cur !== 16'h0100) $display("FAIL sweep_restart_busy got %h want 0100", freq_cur); else n_pass++;
        tick();
        en = 1'b0; tick(); tick();
        n_total++; if ({busy, freq_cur} !== {1'b1, 16'h0200}) $display("FAIL sweep_en_hold got busy=%b freq=%h want 1 0200", busy, freq_cur); else n_pass++;
        en = 1'b1; tick();
        n_total++; if (freq_cur !== 16'h0300) $display("FAIL sweep_en_resume got %h want 0300", freq_cur); else n_pass++;
        tick();
        n_total++; if ({busy, freq_cur} !== {1'b0, 16'h0400}) $display("FAIL sweep_en_end got busy=%b freq=%h want 0 0400", busy, freq_cur); else n_pass++;
    endtask

    task automatic test_sweep_cont();
        logic [PHASE_W-1:0] ef [11] = '{16'h100, 16'h200, 16'h300, 16'h400, 16'h300, 16'h200,
                                        16'h100, 16'h200, 16'h300, 16'h400, 16'h300};
        do_reset();
        mode = 2'd3; freq_start = 16'h0100; freq_stop = 16'h0400; freq_step = 16'h0100; en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            n_total++; if ({busy, freq_cur} !== {1'b1, ef[i]}) $display("FAIL tri i=%0d got busy=%b freq=%h want 1 %h", i, busy, freq_cur, ef[i]); else n_pass++;
            if (i < 10) tick();
        end
        mode = 2'd1; tick();
        n_total++; if ({busy, freq_cur} !== {1'b0, 16'h0100}) $display("FAIL tri_to_fixed got busy=%b freq=%h want 0 0100", busy, freq_cur); else n_pass++;
    endtask

    task automatic test_boundaries();
        int busy_seen;
        // rst mid-sweep
        do_reset();
        mode = 2'd2; freq_start = 16'h0100; freq_stop = 16'h4000; freq_step = 16'h0100; en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_total++; if ({busy, valid} !== 2'b11) $display("FAIL midsweep_pre busy=%b valid=%b want 1 1", busy, valid); else n_pass++;
        rst = 1'b1; tick();
        n_total++; if ({phase_out, freq_cur, signal_out, busy, valid} !== '0)
            $display("FAIL rst_midsweep phase=%h freq=%h sig=%0d busy=%b valid=%b want all 0", phase_out, freq_cur, signal_out, busy, valid); else n_pass++;
        rst = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); busy_seen += int'(busy); end
        n_total++; if (busy_seen != 0 || freq_cur !== 16'h0) $display("FAIL rst_no_resume busy_cycles=%0d freq=%h want 0 0000", busy_seen, freq_cur); else n_pass++;
        // inverted range
        freq_start = 16'h0500; freq_stop = 16'h0400;
        start = 1'b1; tick(); start = 1'b0;
        busy_seen = int'(busy);
        for (int i = 0; i < 4; i++) begin tick(); busy_seen += int'(busy); end
        n_total++; if (busy_seen != 0 || freq_cur !== 16'h0500) $display("FAIL inverted busy_cycles=%0d freq=%h want 0 0500", busy_seen, freq_cur); else n_pass++;
        // zero step
        freq_start = 16'h0300; freq_stop = 16'h0400; freq_step = 16'h0000;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_total++; if ({busy, freq_cur} !== {1'b1, 16'h0300}) $display("FAIL zero_step got busy=%b freq=%h want 1 0300", busy, freq_cur); else n_pass++;
        // start ignored in mode 1
        mode = 2'd1; freq_start = 16'h1357; tick();
        start = 1'b1; tick(); start = 1'b0; tick();
        n_total++; if ({busy, freq_cur} !== {1'b0, 16'h1357}) $display("FAIL start_mode1 got busy=%b freq=%h want 0 1357", busy, freq_cur); else n_pass++;
        for (int i = 0; i < 4; i++) tick();
        n_total++; if (valid !== 1'b1) $display("FAIL mode1_valid got %b want 1", valid); else n_pass++;
        // mode 0
        mode = 2'd0; #1;
        n_total++; if ({valid, signal_out} !== 9'h0) $display("FAIL mode0_comb valid=%b sig=%0d want 0 0", valid, signal_out); else n_pass++;
        tick();
        n_total++; if ({valid, signal_out, phase_out, freq_cur} !== '0)
            $display("FAIL mode0 valid=%b sig=%0d phase=%h freq=%h want all 0", valid, signal_out, phase_out, freq_cur); else n_pass++;
    endtask

    task automatic test_random_fixed();
        for (int run = 0; run < 3; run++) begin
            logic [PHASE_W-1:0] acc_m, freq_m, fs;
            logic [PHASE_W-1:0] pq[$];
            bit                 eh[$];
            logic signed [DATA_W-1:0] e;
            int n_en;
            do_reset();
            acc_m = '0; freq_m = '0; n_en = 0;
            fs = 16'($urandom);
            mode = 2'd1; freq_start = fs;
            for (int c = 0; c < 150; c++) begin
                en = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                phase_offset = 16'($urandom);
                if (en) begin
                    pq.push_back(acc_m + phase_offset);
                    acc_m = acc_m + freq_m;
                    n_en++;
                end
                freq_m = fs;
                eh.push_back(en);
                tick();
                n_total++; if (phase_out !== acc_m) $display("FAIL rnd_phase run=%0d c=%0d got %h want %h", run, c, phase_out, acc_m); else n_pass++;
                if (eh.size() >= 3) begin
                    n_total++; if (valid !== eh[eh.size()-3]) $display("FAIL rnd_valid run=%0d c=%0d got %b want %b", run, c, valid, eh[eh.size()-3]); else n_pass++;
                end
                if (n_en >= 3) begin
                    e = ref_sine(pq[n_en-3]);
                    n_total++; if (signal_out !== e) $display("FAIL rnd_sample run=%0d c=%0d got %0d want %0d", run, c, signal_out, e); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random_sweep();
        for (int run = 0; run < 6; run++) begin
            longint seq[$];
            longint fs, fe, st, s;
            int stop_idx, idx;
            bit up, eb;
            do_reset();
            fs = longint'($urandom_range(0, 16'h8000));
            fe = fs + longint'($urandom_range(1, 16'h4000));
            st = longint'($urandom_range(int'((fe - fs) / 20) + 1, int'(fe - fs) + 16'h0200));
            mode = (run % 2 == 1) ? 2'd3 : 2'd2;
            freq_start = 16'(fs); freq_stop = 16'(fe); freq_step = 16'(st);
            seq.push_back(fs); up = 1'b1; stop_idx = -1;
            while (seq.size() < 60) begin
                if (mode == 2'd2 && stop_idx >= 0) begin
                    seq.push_back(fe);
                end else if (up) begin
                    s = seq[$] + st;
                    if (s >= fe) begin seq.push_back(fe); up = 1'b0; if (stop_idx < 0) stop_idx = seq.size() - 1; end
                    else seq.push_back(s);
                end else begin
                    s = seq[$] - st;
                    if (s <= fs) begin seq.push_back(fs); up = 1'b1; end
                    else seq.push_back(s);
                end
            end
            en = 1'b1; start = 1'b1; tick(); start = 1'b0;
            idx = 0;
            for (int c = 0; c < 70; c++) begin
                eb = (mode == 2'd3) || (idx < stop_idx);
                n_total++; if ({busy, freq_cur} !== {eb, 16'(seq[idx])})
                    $display("FAIL rnd_sweep run=%0d c=%0d got busy=%b freq=%h want %b %h", run, c, busy, freq_cur, eb, 16'(seq[idx])); else n_pass++;
                en = ($urandom_range(0, 3) != 0);
                tick();
                if (en && idx < 59) idx++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_offset();
        test_nyquist();
        test_sweep_single();
        test_sweep_cont();
        test_boundaries();
        test_random_fixed();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dds_sweep_gen.md
Name: dds_sweep_gen

Overview:
Parametrised direct digital synthesiser, the next generation of the team's 4-bit phase-accumulator DDS. Adds a wide phase accumulator, a programmable phase offset, a quarter-wave sine LUT with symmetry folding and signed output, and a linear frequency-sweep (chirp) state machine. Sits between the control registers and the DAC/scope output path and produces one sample per enabled clock.

Parameters:
PHASE_W, 16, phase accumulator and frequency word width (bits)
ADDR_W, 8, full-period LUT address width; quarter table holds 2^(ADDR_W-2) entries
DATA_W, 8, signed sample width

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
en  in  1  clock enable; accumulator, FSM and pipeline advance only when high
mode  in  2  0=off, 1=fixed frequency, 2=single sweep up, 3=continuous up/down sweep
start  in  1  single-cycle pulse that launches a sweep (modes 2/3)
freq_start  in  PHASE_W  fixed frequency (mode 1) / sweep start word
freq_stop  in  PHASE_W  sweep end word
freq_step  in  PHASE_W  sweep increment per enabled cycle
phase_offset  in  PHASE_W  added to accumulator before LUT addressing
busy  out  1  high while the FSM is in SWEEP_UP or SWEEP_DOWN
freq_cur  out  PHASE_W  frequency word currently applied
phase_out  out  PHASE_W  accumulator value (pre-offset)
signal_out  out  DATA_W  signed two's-complement sine sample
valid  out  1  signal_out holds a live sample

Behaviour:
- Reset: acc, freq_cur, phase_out, signal_out = 0; busy = 0; valid = 0; FSM = IDLE; pipeline cleared.
- Accumulator: when en, acc <= acc + freq_cur, modulo 2^PHASE_W (natural wrap, no saturation). mode 0 forces acc = 0 and freq_cur = 0.
- Phase path: p = acc + phase_offset (mod 2^PHASE_W); addr = p[PHASE_W-1 -: ADDR_W]; quadrant q = addr[ADDR_W-1:ADDR_W-2]; idx = addr[ADDR_W-3:0], mirrored (bitwise inverted) when q is 1 or 3; output negated when q is 2 or 3.
- LUT entry i = round((2^(DATA_W-1)-1) * sin(2*pi*(i+0.5)/2^ADDR_W)). The half-LSB offset makes the mirroring exact; no zero-crossing duplicates. Negation never overflows.
- Latency: 3 enabled cycles, accumulator value to signal_out (stage 1 offset add, stage 2 fold and LUT read, stage 3 sign apply). While en is low, all stages hold.
- valid: en delayed through a 3-deep shift register, ANDed with (mode != 0). valid = 0 whenever mode = 0, and signal_out is then forced to 0.
- FSM states: IDLE, SWEEP_UP, SWEEP_DOWN, HOLD.
  - IDLE: mode 1 sets freq_cur = freq_start every cycle. start while mode is 2 or 3 loads freq_cur = freq_start and moves to SWEEP_UP.
  - SWEEP_UP, each enabled cycle: sum = freq_cur + freq_step, computed at PHASE_W+1 bits. If sum >= freq_stop, freq_cur = freq_stop and the FSM goes to HOLD (mode 2) or SWEEP_DOWN (mode 3). Otherwise freq_cur = sum.
  - SWEEP_DOWN: diff = freq_cur - freq_step, signed at PHASE_W+1 bits. If diff <= freq_start, freq_cur = freq_start and the FSM goes to SWEEP_UP. Otherwise freq_cur = diff.
  - HOLD: freq_cur is held and busy = 0. A new start restarts the sweep from freq_start.
- Boundaries:
  - freq_start >= freq_stop at start: go directly to HOLD with freq_cur = freq_start.
  - freq_step = 0: freq_cur stays at freq_start and busy stays high.
  - start while busy: restarts from freq_start. start in mode 0/1: ignored.
  - Any change of mode to 0 or 1 while not IDLE: FSM returns to IDLE next cycle.
  - rst mid-sweep: reset values apply on the next edge; no sweep resumes.
  - Sweep-word inputs are sampled live and are to be held stable during a sweep.

Optional Feature:
DDS_DITHER_EN: when defined, a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset; advances when en) adds its low (PHASE_W-ADDR_W) bits to p before truncation. This spreads truncation spurs. It requires PHASE_W-ADDR_W <= 16, enforced by an elaboration check. When undefined: pure truncation, no LFSR logic, fully deterministic output. All test-plan values below assume undefined.

Test Plan:
- Default params, mode 1, freq_start=0x0100, offset 0, en=1 -> addr steps by 1 per cycle, period 256 cycles; first valid sample = 2, sample at addr 64 = 127, at addr 128 = -2, at addr 192 = -127; valid rises 3 cycles after en.
- mode 1, freq_start=0x0100, phase_offset=0x4000 -> first valid sample = 127; phase_out unaffected by the offset.
- mode 1, freq_start=0x8000 -> accumulator wraps every 2 cycles; signal_out alternates 2, -2.
- mode 2, start=0x0100, stop=0x0400, step=0x0100, start pulse -> freq_cur 0x100, 0x200, 0x300, 0x400, then HOLD; busy high for exactly 3 enabled cycles. Repeat with en toggling 1-0-1 -> freq_cur holds during en=0.
- mode 3, same words -> freq_cur 0x100..0x400..0x100..0x400 triangle, busy constantly high. Switching mode to 1 -> IDLE next cycle, freq_cur = freq_start.
- Boundary cases:
  - rst asserted mid-sweep -> all outputs 0 next edge.
  - start with freq_start=0x0500 > stop=0x0400 -> HOLD, freq_cur=0x0500, busy never rises.
  - mode 0 -> valid=0, signal_out=0.
